// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Arbitrates two requesters onto one shared single-port data memory.
// The grant is combinational, so an accepted request reaches the memory in the
// same cycle. The matching response (rsp_valid plus registered read data) comes
// out on the following cycle. Requesters that tie alternate by last-granted.
// An owner keeps the port for at most MAX_BURST consecutive beats while the
// other requester is waiting.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   rN_valid_i/rN_ready_o  request handshake (transfer on valid && ready)
//   rN_addr_i              word address (DEPTH bits)
//   rN_wsel_i              byte write enables, all-zero means read
//   rN_wdata_i             write data
//   rN_rsp_valid_o         one-cycle pulse, one cycle after acceptance
//   rN_rdata_o             read data (0 for writes), held until next response
//   mem_en_o               memory access enable
//   mem_addr_o             memory address
//   mem_wsel_byte_o        memory byte write enables
//   mem_wdata_o            memory write data
//   mem_rdata_i            memory read data, valid in the same cycle as mem_en_o
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 10,
    parameter int MAX_BURST = 4
) (
    input  logic               clk_i,
    input  logic               rstn_i,

    input  logic               r0_valid_i,
    output logic               r0_ready_o,
    input  logic [DEPTH-1:0]   r0_addr_i,
    input  logic [WIDTH/8-1:0] r0_wsel_i,
    input  logic [WIDTH-1:0]   r0_wdata_i,
    output logic               r0_rsp_valid_o,
    output logic [WIDTH-1:0]   r0_rdata_o,

    input  logic               r1_valid_i,
    output logic               r1_ready_o,
    input  logic [DEPTH-1:0]   r1_addr_i,
    input  logic [WIDTH/8-1:0] r1_wsel_i,
    input  logic [WIDTH-1:0]   r1_wdata_i,
    output logic               r1_rsp_valid_o,
    output logic [WIDTH-1:0]   r1_rdata_o,

    output logic               mem_en_o,
    output logic [DEPTH-1:0]   mem_addr_o,
    output logic [WIDTH/8-1:0] mem_wsel_byte_o,
    output logic [WIDTH-1:0]   mem_wdata_o,
    input  logic [WIDTH-1:0]   mem_rdata_i
);

    localparam int BW = WIDTH / 8;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    logic          gnt0, gnt1;
    logic          idle_g0, idle_g1;
    logic [CW-1:0] cnt_inc;

    // Tie-break used whenever nobody holds the port: a lone requester wins,
    // two requesters go to the one that was not granted last.
    assign idle_g0 = r0_valid_i && (!r1_valid_i || last_q);
    assign idle_g1 = r1_valid_i && (!r0_valid_i || !last_q);

    // Counter saturates at the limit. An owner running alone past the limit
    // keeps the port but must still yield at once when the other shows up.
    assign cnt_inc = (cnt_q == BURST_LIMIT) ? cnt_q : cnt_q + CW'(1);

    // ---------------------------------------------------------------------
    // Grant selection and next state
    // ---------------------------------------------------------------------
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = last_q;

        // Nothing is granted while reset is held, whatever the valids do.
        if (rstn_i) begin
            case (state_q)
                OWN0: begin
                    if (r0_valid_i) begin
                        if (cnt_q < BURST_LIMIT || !r1_valid_i) gnt0 = 1'b1;
                        else                                     gnt1 = 1'b1;
                    end else begin
                        // Owner dropped valid: release in this same cycle.
                        gnt0 = idle_g0;
                        gnt1 = idle_g1;
                    end
                end
                OWN1: begin
                    if (r1_valid_i) begin
                        if (cnt_q < BURST_LIMIT || !r0_valid_i) gnt1 = 1'b1;
                        else                                     gnt0 = 1'b1;
                    end else begin
                        gnt0 = idle_g0;
                        gnt1 = idle_g1;
                    end
                end
                default: begin
                    gnt0 = idle_g0;
                    gnt1 = idle_g1;
                end
            endcase
        end

        if (gnt0) begin
            state_d = OWN0;
            last_d  = 1'b0;
            cnt_d   = (state_q == OWN0) ? cnt_inc : CW'(1);
        end else if (gnt1) begin
            state_d = OWN1;
            last_d  = 1'b1;
            cnt_d   = (state_q == OWN1) ? cnt_inc : CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;    // requester 0 wins the first tie
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign r0_ready_o = gnt0;
    assign r1_ready_o = gnt1;

    // ---------------------------------------------------------------------
    // Memory port mux
    // ---------------------------------------------------------------------
    always_comb begin
        mem_en_o        = gnt0 | gnt1;
        mem_addr_o      = '0;
        mem_wsel_byte_o = '0;
        mem_wdata_o     = '0;
        if (gnt0) begin
            mem_addr_o      = r0_addr_i;
            mem_wsel_byte_o = r0_wsel_i;
            mem_wdata_o     = r0_wdata_i;
        end else if (gnt1) begin
            mem_addr_o      = r1_addr_i;
            mem_wsel_byte_o = r1_wsel_i;
            mem_wdata_o     = r1_wdata_i;
        end
    end

    // ---------------------------------------------------------------------
    // Per-requester response registers
    // ---------------------------------------------------------------------
    logic             gnt_a       [2];
    logic [BW-1:0]    wsel_a      [2];
    logic             rsp_valid_a [2];
    logic [WIDTH-1:0] rdata_a     [2];

    assign gnt_a[0]  = gnt0;
    assign gnt_a[1]  = gnt1;
    assign wsel_a[0] = r0_wsel_i;
    assign wsel_a[1] = r1_wsel_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic             rsp_valid_q, rsp_valid_d;
        logic [WIDTH-1:0] rdata_q, rdata_d;

        always_comb begin
            rsp_valid_d = gnt_a[gi];
            rdata_d     = rdata_q;
            if (gnt_a[gi]) begin
                rdata_d = (wsel_a[gi] == '0) ? mem_rdata_i : '0;
            end
        end

        // Reset clears any pending response, so a request accepted just
        // before reset never produces a pulse afterwards.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                rsp_valid_q <= 1'b0;
                rdata_q     <= '0;
            end else begin
                rsp_valid_q <= rsp_valid_d;
                rdata_q     <= rdata_d;
            end
        end

        assign rsp_valid_a[gi] = rsp_valid_q;
        assign rdata_a[gi]     = rdata_q;
    end

    assign r0_rsp_valid_o = rsp_valid_a[0];
    assign r0_rdata_o     = rdata_a[0];
    assign r1_rsp_valid_o = rsp_valid_a[1];
    assign r1_rdata_o     = rdata_a[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter with default parameters (32-bit words,
// 10-bit addresses, bursts of 4). A behavioural memory sits on the memory port.
// Each vector gives the requester inputs and the grants expected from them.
// When a grant is expected, the expected response is taken from a separate
// reference copy of the memory and pushed to a per-requester queue. The queue
// is popped when the DUT pulses rsp_valid.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        rstn;
    logic        r0_valid, r0_ready, r0_rsp_valid;
    logic [9:0]  r0_addr;
    logic [3:0]  r0_wsel;
    logic [31:0] r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_rsp_valid;
    logic [9:0]  r1_addr;
    logic [3:0]  r1_wsel;
    logic [31:0] r1_wdata, r1_rdata;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_wsel;
    logic [31:0] mem_wdata, mem_rdata;

    dmem_arbiter dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .r0_valid_i     (r0_valid),
        .r0_ready_o     (r0_ready),
        .r0_addr_i      (r0_addr),
        .r0_wsel_i      (r0_wsel),
        .r0_wdata_i     (r0_wdata),
        .r0_rsp_valid_o (r0_rsp_valid),
        .r0_rdata_o     (r0_rdata),
        .r1_valid_i     (r1_valid),
        .r1_ready_o     (r1_ready),
        .r1_addr_i      (r1_addr),
        .r1_wsel_i      (r1_wsel),
        .r1_wdata_i     (r1_wdata),
        .r1_rsp_valid_o (r1_rsp_valid),
        .r1_rdata_o     (r1_rdata),
        .mem_en_o       (mem_en),
        .mem_addr_o     (mem_addr),
        .mem_wsel_byte_o(mem_wsel),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------------
    // Memory model (driven by the DUT) and reference copy (driven by bench)
    // ---------------------------------------------------------------------
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    assign mem_rdata = mem[mem_addr];

    function automatic logic [31:0] init_word(input int i);
        if (i == 5)  return 32'hDEADBEEF;
        if (i == 16) return 32'h11223344;
        return 32'hA5A50000 + 32'(i) * 32'h00010003;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wsel[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Checking infrastructure
    // ---------------------------------------------------------------------
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];

    task automatic mon_one(input int n, input logic v, input logic [31:0] d);
        rsp_t e;
        int   sz;
        sz = (n == 0) ? q0.size() : q1.size();
        if (v) begin
            if (sz == 0) begin
                chk($sformatf("r%0d_unexpected_rsp@%0d", n, cyc), 64'd1, 64'd0);
            end else begin
                e = (n == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("r%0d_rsp_cycle", n), 64'(cyc), 64'(e.cyc));
                chk($sformatf("r%0d_rdata@%0d", n, cyc), 64'(d), 64'(e.data));
            end
        end else if (sz > 0) begin
            e = (n == 0) ? q0[0] : q1[0];
            if (e.cyc <= cyc) begin
                e = (n == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("r%0d_missing_rsp@%0d", n, e.cyc), 64'd0, 64'd1);
            end
        end
    endtask

    always @(negedge clk) begin
        mon_one(0, r0_rsp_valid, r0_rdata);
        mon_one(1, r1_rsp_valid, r1_rdata);
    end

    // ---------------------------------------------------------------------
    // Vector table
    // ---------------------------------------------------------------------
    typedef struct {
        logic        v0, v1;
        logic [9:0]  a0, a1;
        logic [3:0]  ws0, ws1;
        logic [31:0] wd0, wd1;
        logic        g0, g1;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic v0, input logic v1,
                                input logic [9:0] a0, input logic [9:0] a1,
                                input logic [3:0] ws0, input logic [3:0] ws1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic g0, input logic g1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1;
        v.ws0 = ws0; v.ws1 = ws1; v.wd0 = wd0; v.wd1 = wd1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Drive one vector: inputs just after the edge, comb outputs checked
    // mid-cycle, expected responses queued against the reference memory.
    task automatic apply(input vec_t v, input int idx);
        rsp_t        e;
        logic [3:0]  exp_ws;
        @(posedge clk); #1;
        r0_valid = v.v0; r0_addr = v.a0; r0_wsel = v.ws0; r0_wdata = v.wd0;
        r1_valid = v.v1; r1_addr = v.a1; r1_wsel = v.ws1; r1_wdata = v.wd1;
        #3;
        exp_ws = v.g0 ? v.ws0 : (v.g1 ? v.ws1 : 4'h0);
        chk($sformatf("v%0d_ready0", idx), 64'(r0_ready), 64'(v.g0));
        chk($sformatf("v%0d_ready1", idx), 64'(r1_ready), 64'(v.g1));
        chk($sformatf("v%0d_mem_en", idx), 64'(mem_en), 64'(v.g0 | v.g1));
        chk($sformatf("v%0d_mem_wsel", idx), 64'(mem_wsel), 64'(exp_ws));
        if (v.g0 || v.g1) begin
            chk($sformatf("v%0d_mem_addr", idx), 64'(mem_addr), 64'(v.g0 ? v.a0 : v.a1));
            chk($sformatf("v%0d_mem_wdata", idx), 64'(mem_wdata), 64'(v.g0 ? v.wd0 : v.wd1));
        end
        if (v.g0) begin
            e.cyc  = cyc + 1;
            e.data = (v.ws0 == 4'h0) ? ref_mem[v.a0] : 32'h0;
            q0.push_back(e);
            ref_mem[v.a0] = merge(ref_mem[v.a0], v.wd0, v.ws0);
        end
        if (v.g1) begin
            e.cyc  = cyc + 1;
            e.data = (v.ws1 == 4'h0) ? ref_mem[v.a1] : 32'h0;
            q1.push_back(e);
            ref_mem[v.a1] = merge(ref_mem[v.a1], v.wd1, v.ws1);
        end
    endtask

    vec_t none_v;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        none_v = mk(0, 0, 10'h0, 10'h0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0);

        // Single read, byte write then read-back
        vt.push_back(mk(1, 0, 10'h005, 10'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 0));
        vt.push_back(none_v);
        vt.push_back(mk(0, 1, 10'h0, 10'h010, 4'h0, 4'b0010, 32'h0, 32'h0000AB00, 0, 1));
        vt.push_back(mk(0, 1, 10'h0, 10'h010, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1));
        vt.push_back(none_v);
        // Tie out of idle with last-granted = 1: 0,0,0,0,1,1,1,1,0
        for (int i = 0; i < 9; i++)
            vt.push_back(mk(1, 1, 10'h020, 10'h030,
                            (i == 0) ? 4'b1001 : 4'h0, (i == 4) ? 4'b0110 : 4'h0,
                            $urandom, $urandom,
                            (i < 4) || (i == 8), (i >= 4) && (i < 8)));
        // Early release: r0 drops after its 2nd beat, r1 starts a fresh burst
        vt.push_back(mk(1, 1, 10'h021, 10'h031, 4'h0, 4'h0, 32'h0, 32'h0, 1, 0));
        vt.push_back(mk(0, 1, 10'h021, 10'h005, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(1, 1, 10'h022, 10'h032, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1));
        vt.push_back(mk(1, 1, 10'h022, 10'h032, 4'h0, 4'h0, 32'h0, 32'h0, 1, 0));
        // Idle tie after r0 was last: r1 wins
        vt.push_back(none_v);
        vt.push_back(mk(1, 1, 10'h023, 10'h033, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1));
        vt.push_back(none_v);
        // Lone owner past the burst limit keeps the port, yields when r1 arrives
        for (int i = 0; i < 6; i++)
            vt.push_back(mk(1, 0, 10'h3FF, 10'h0, (i == 0) ? 4'hF : 4'h0, 4'h0,
                            $urandom, 32'h0, 1, 0));
        vt.push_back(mk(1, 1, 10'h3FF, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 0, 1));
        // Idle stretch
        for (int i = 0; i < 10; i++) vt.push_back(none_v);
        // Read just before the mid-access reset (leaves rdata0 non-zero)
        vt.push_back(mk(1, 0, 10'h005, 10'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 0));

        // ---- reset state, valids held high during reset ----
        rstn = 1'b0;
        r0_valid = 1'b1; r0_addr = 10'h005; r0_wsel = 4'h0; r0_wdata = 32'h0;
        r1_valid = 1'b1; r1_addr = 10'h010; r1_wsel = 4'hF; r1_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready0", 64'(r0_ready), 64'd0);
        chk("rst_ready1", 64'(r1_ready), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_wsel", 64'(mem_wsel), 64'd0);
        chk("rst_rsp_valid", 64'({r0_rsp_valid, r1_rsp_valid}), 64'd0);
        chk("rst_rdata0", 64'(r0_rdata), 64'd0);
        chk("rst_rdata1", 64'(r1_rdata), 64'd0);
        @(posedge clk); #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        rstn = 1'b1;

        foreach (vt[i]) apply(vt[i], i);

        // ---- reset mid-access ----
        @(posedge clk); #1;
        r0_valid = 1'b1; r0_addr = 10'h005; r0_wsel = 4'h0;
        r1_valid = 1'b0;
        #3;
        chk("midrst_ready0_before", 64'(r0_ready), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_ready0_in_reset", 64'(r0_ready), 64'd0);
        chk("midrst_mem_en_in_reset", 64'(mem_en), 64'd0);
        chk("midrst_rdata0", 64'(r0_rdata), 64'd0);
        chk("midrst_rdata1", 64'(r1_rdata), 64'd0);
        @(posedge clk); #1;
        chk("midrst_no_rsp", 64'(r0_rsp_valid), 64'd0);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_rdata0_after", 64'(r0_rdata), 64'd0);
        // Back in IDLE with last-granted reset: tie goes to r0
        apply(mk(1, 1, 10'h010, 10'h011, 4'h0, 4'h0, 32'h0, 32'h0, 1, 0), 1000);
        apply(none_v, 1001);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 10, memory address width in bits (word-addressed).
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive grants to one owner while the other requester waits (>=1).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i input 1 (all state on rising edge); rstn_i input 1 (active-low async reset).
REQ-005 SHALL have, for requester n in {0,1}:
- rN_valid_i input 1: request present
- rN_ready_o output 1: request accepted this cycle
- rN_addr_i input DEPTH: word address
- rN_wsel_i input WIDTH/8: byte write enables; all-zero = read
- rN_wdata_i input WIDTH: write data
- rN_rsp_valid_o output 1: response for an accepted request
- rN_rdata_o output WIDTH: read data
REQ-006 SHALL have memory-side ports driving one shared memory port (combinational read, byte-enabled write on clock edge):
- mem_en_o output 1: access enable
- mem_addr_o output DEPTH: address
- mem_wsel_byte_o output WIDTH/8: byte write enables
- mem_wdata_o output WIDTH: write data
- mem_rdata_i input WIDTH: read data, valid same cycle as mem_en_o

Function
REQ-007 SHALL keep owner FSM states IDLE, OWN0, OWN1, plus a burst counter (ceil(log2(MAX_BURST+1)) bits) and a last-granted bit.
REQ-008 SHALL choose the grant combinationally each cycle:
- IDLE, one valid: grant it
- IDLE, both valid: grant the requester not last granted
- OWNn with rN_valid_i=1 and counter<MAX_BURST: grant n
- OWNn with counter==MAX_BURST and other valid: grant other
- OWNn with rN_valid_i=0: behave as IDLE
REQ-009 SHALL assert rN_ready_o only for the granted requester, and only when its valid is high; never both in the same cycle.
REQ-010 SHALL, in a grant cycle, assert mem_en_o=1 and drive mem_addr_o/mem_wsel_byte_o/mem_wdata_o from the granted requester; when there is no grant, mem_en_o=0 and mem_wsel_byte_o=0.
REQ-011 SHALL perform a transfer when valid && ready; there is no stall and one transfer per cycle maximum.
REQ-012 SHALL, on the edge after a grant, enter OWNn for granted n, set last-granted=n, load counter=1 on an owner change, else increment; with no grant, go to IDLE and clear the counter.
REQ-013 SHALL pulse rN_rsp_valid_o for exactly one cycle, one cycle after each accepted request (reads and writes).
REQ-014 SHALL register rN_rdata_o from mem_rdata_i in the acceptance cycle for reads; for writes the registered value SHALL be 0; rN_rdata_o holds until the next response for that requester.
REQ-015 SHALL not backpressure responses; requesters always accept rsp.
REQ-016 SHALL treat addresses as raw DEPTH-bit values with no wrap logic; address bounds are the requester's responsibility.
REQ-017 SHALL, when requester n deasserts valid mid-burst, release ownership the same cycle; the other requester is granted that cycle if valid.
REQ-018 SHALL give a requester that holds valid with a changing payload no ordering guarantees; a request is consumed only on ready.

Reset
REQ-019 SHALL, while rstn_i=0, force state=IDLE, counter=0, last-granted=1 (requester 0 wins first tie), rN_rsp_valid_o=0, rN_rdata_o=0.
REQ-020 SHALL, when reset is asserted mid-access, drop any pending response: no rsp_valid after reset release for pre-reset requests.
REQ-021 SHALL keep rN_ready_o/mem_en_o combinational and 0 during reset regardless of valid inputs.

Verification
REQ-022 Single read: r0 read addr 0x005, mem[5]=0xDEADBEEF -> r0_ready_o same cycle, r0_rsp_valid_o next cycle, r0_rdata_o=0xDEADBEEF.
REQ-023 Byte write then read: r1 wsel=4'b0010, wdata=0x0000AB00 to addr 0x010 (old 0x11223344) -> ack next cycle with rdata 0; a subsequent read returns 0x1122AB44.
REQ-024 Tie out of reset: both valid continuously, MAX_BURST=4 -> grant order 0,0,0,0,1,1,1,1,0...; never both ready.
REQ-025 Early release: r0 owns burst, drops valid after 2 beats, r1 valid -> r1 granted that cycle, counter=1.
REQ-026 Reset mid-access: read accepted, rstn_i low before next edge -> no rsp_valid, rdata=0, state IDLE.
REQ-027 Idle: no valids for 10 cycles -> mem_en_o=0, mem_wsel_byte_o=0, no rsp pulses.
